proximity_alarm: RTL and testbench

- Downstream consumer of the ultrasonic range finder's 8-bit distance (cm) result.
- Smooths raw readings with a 4-sample moving average and classifies the result into proximity zones with hysteresis.
- Drives a buzzer pattern per zone and flags stale data when the sensor stops reporting.
- Sits between range_finder and board I/O (buzzer pin, status LEDs).

---
 rtl/proximity_alarm.sv | 144 ++++++++++++++
 tb/tb_proximity_alarm.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/proximity_alarm.sv
// Proximity alarm: 4-sample moving average of range-finder distance, zone
// classification with hysteresis, stale-data timeout and per-zone buzzer pattern.
module proximity_alarm #(
    parameter int unsigned NEAR_CM        = 20,
    parameter int unsigned FAR_CM         = 40,
    parameter int unsigned HYST_CM        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 100000000,
    parameter int unsigned BEEP_ON_CYCLES = 5000000,
    parameter int unsigned WARN_PERIOD    = 25000000,
    parameter int unsigned STALE_PERIOD   = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] distance,
    input  logic       dist_valid,
    output logic [7:0] avg_dist,
    output logic       avg_valid,
    output logic [1:0] zone,
    output logic       buzzer
);

    localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned PMAX = (WARN_PERIOD > STALE_PERIOD) ? WARN_PERIOD : STALE_PERIOD;
    localparam int unsigned PW   = $clog2(PMAX);

    localparam logic [7:0] NEAR_TH    = 8'(NEAR_CM);
    localparam logic [7:0] FAR_TH     = 8'(FAR_CM);
    localparam logic [7:0] WARN_EXIT  = 8'(NEAR_CM + HYST_CM);
    localparam logic [7:0] CLEAR_EXIT = 8'(FAR_CM + HYST_CM);

    typedef enum logic [1:0] {
        Z_CLEAR  = 2'd0,
        Z_WARN   = 2'd1,
        Z_DANGER = 2'd2,
        Z_STALE  = 2'd3
    } zone_t;

    zone_t           zone_q;
    zone_t           zone_nxt;
    logic [3:0][7:0] hist;
    logic [9:0]      sum;
    logic [9:0]      sum_nxt;
    logic            primed;
    logic [TW-1:0]   to_cnt;
    logic [PW-1:0]   pat_cnt;
    logic [PW-1:0]   pat_nxt;
    logic            accept;
    logic            to_hit;
    logic            buzz_c;

    // distance 0 means "no echo" and is not a measurement
    assign accept = dist_valid && (distance != 8'd0);
    assign to_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1)) && !accept;
    assign zone   = zone_q;

    // hist[3] is the oldest slot; modular 10-bit math is exact since the result fits
    always_comb begin
        sum_nxt = sum + 10'(distance) - 10'(hist[3]);
    end

    // Zone classification on the cycle after avg_valid; timeout has priority
    always_comb begin
        zone_nxt = zone_q;
        if (to_hit) begin
            zone_nxt = Z_STALE;
        end else if (avg_valid) begin
            case (zone_q)
                Z_WARN: begin
                    if (avg_dist <= NEAR_TH)         zone_nxt = Z_DANGER;
                    else if (avg_dist >= CLEAR_EXIT) zone_nxt = Z_CLEAR;
                end
                Z_DANGER: begin
                    if (avg_dist >= CLEAR_EXIT)      zone_nxt = Z_CLEAR;
                    else if (avg_dist >= WARN_EXIT)  zone_nxt = Z_WARN;
                end
                default: begin
                    if (avg_dist <= NEAR_TH)         zone_nxt = Z_DANGER;
                    else if (avg_dist <= FAR_TH)     zone_nxt = Z_WARN;
                    else                             zone_nxt = Z_CLEAR;
                end
            endcase
        end
    end

    // Pattern counter restarts on any zone change and only runs in beeping zones
    always_comb begin
        pat_nxt = '0;
        if (zone_nxt == zone_q) begin
            case (zone_q)
                Z_WARN:  pat_nxt = (pat_cnt == PW'(WARN_PERIOD - 1))  ? '0 : pat_cnt + PW'(1);
                Z_STALE: pat_nxt = (pat_cnt == PW'(STALE_PERIOD - 1)) ? '0 : pat_cnt + PW'(1);
                default: pat_nxt = '0;
            endcase
        end
    end

    always_comb begin
        buzz_c = 1'b0;
        case (zone_q)
            Z_WARN:   buzz_c = (pat_cnt < PW'(BEEP_ON_CYCLES));
            Z_DANGER: buzz_c = 1'b1;
            Z_STALE:  buzz_c = (pat_cnt < PW'(BEEP_ON_CYCLES / 2));
            default:  buzz_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist      <= '0;
            sum       <= '0;
            primed    <= 1'b0;
            to_cnt    <= '0;
            avg_dist  <= '0;
            avg_valid <= 1'b0;
            zone_q    <= Z_STALE;
            pat_cnt   <= '0;
            buzzer    <= 1'b0;
        end else begin
            avg_valid <= accept;
            if (accept) begin
                to_cnt <= '0;
                if (!primed) begin
                    // first sample after reset or stale seeds the whole window
                    hist     <= {4{distance}};
                    sum      <= {distance, 2'b00};
                    avg_dist <= distance;
                    primed   <= 1'b1;
                end else begin
                    hist     <= {hist[2:0], distance};
                    sum      <= sum_nxt;
                    avg_dist <= sum_nxt[9:2];
                end
            end else if (to_hit) begin
                primed <= 1'b0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
            zone_q  <= zone_nxt;
            pat_cnt <= pat_nxt;
            buzzer  <= buzz_c;
        end
    end

endmodule

// File: tb/tb_proximity_alarm.sv
// Directed bench for proximity_alarm with shortened timing parameters.
module tb_proximity_alarm;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] distance;
    logic       dist_valid;
    logic [7:0] avg_dist;
    logic       avg_valid;
    logic [1:0] zone;
    logic       buzzer;

    int n_cmp = 0;
    int n_err = 0;

    proximity_alarm #(
        .NEAR_CM(20), .FAR_CM(40), .HYST_CM(3),
        .TIMEOUT_CYCLES(1000), .BEEP_ON_CYCLES(10),
        .WARN_PERIOD(50), .STALE_PERIOD(100)
    ) dut (
        .clk(clk), .rst(rst), .distance(distance), .dist_valid(dist_valid),
        .avg_dist(avg_dist), .avg_valid(avg_valid), .zone(zone), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one sample for one edge; returns at the following negedge
    task automatic send(input logic [7:0] d);
        distance   = d;
        dist_valid = 1'b1;
        @(negedge clk);
        dist_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int exp_avg [4] = '{90, 80, 70, 60};
    int exp_big [4] = '{213, 227, 241, 255};

    initial begin
        rst        = 1'b1;
        distance   = 8'd0;
        dist_valid = 1'b0;
        idle(3);
        check("rst_avg", avg_dist, 0);
        check("rst_valid", avg_valid, 0);
        check("rst_zone", zone, 3);
        check("rst_buzz", buzzer, 0);
        rst = 1'b0;
        idle(1);
        check("stale_beep_start", buzzer, 1);
        check("stale_zone", zone, 3);

        // prefill
        send(8'd100);
        check("prefill_valid", avg_valid, 1);
        check("prefill_avg", avg_dist, 100);
        check("prefill_zone_lag", zone, 3);
        idle(1);
        check("prefill_zone", zone, 0);
        check("prefill_valid_pulse", avg_valid, 0);
        idle(1);
        check("clear_buzz", buzzer, 0);

        // averaging
        for (int i = 0; i < 4; i++) begin
            send(8'd60);
            check($sformatf("avg_step%0d", i), avg_dist, exp_avg[i]);
        end
        idle(1);
        check("avg_zone", zone, 0);
        send(8'd0);
        check("noecho_valid", avg_valid, 0);
        check("noecho_avg", avg_dist, 60);

        // hysteresis WARN -> CLEAR
        do_reset();
        send(8'd30);
        idle(1);
        check("warn_enter", zone, 1);
        repeat (4) send(8'd42);
        check("avg42", avg_dist, 42);
        idle(1);
        check("warn_hold42", zone, 1);
        repeat (4) send(8'd43);
        check("avg43", avg_dist, 43);
        idle(1);
        check("clear_at43", zone, 0);

        // WARN buzzer pattern starts at its on-phase after entry
        do_reset();
        send(8'd30);
        idle(1);
        check("warn_zone_pat", zone, 1);
        for (int k = 2; k <= 61; k++) begin
            idle(1);
            check($sformatf("warn_buzz_k%0d", k), buzzer, (((k - 2) % 50) < 10) ? 1 : 0);
        end

        // DANGER and hysteresis back to WARN
        do_reset();
        send(8'd15);
        idle(1);
        check("danger_enter", zone, 2);
        repeat (4) send(8'd22);
        check("avg22", avg_dist, 22);
        idle(1);
        check("danger_hold22", zone, 2);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("danger_buzz%0d", k), buzzer, 1);
            idle(1);
        end
        repeat (4) send(8'd23);
        check("avg23", avg_dist, 23);
        idle(1);
        check("warn_at23", zone, 1);
        for (int k = 1; k <= 12; k++) begin
            idle(1);
            check($sformatf("d2w_buzz_k%0d", k), buzzer, (k <= 10) ? 1 : 0);
        end

        // timeout to STALE and recovery
        do_reset();
        send(8'd100);
        idle(998);
        check("pre_timeout_zone", zone, 0);
        idle(1);
        check("edge_timeout_zone", zone, 0);
        idle(1);
        check("timeout_zone", zone, 3);
        for (int k = 1; k <= 100; k++) begin
            idle(1);
            check($sformatf("stale_buzz_k%0d", k), buzzer, (k <= 5) ? 1 : 0);
        end
        check("stale_avg_hold", avg_dist, 100);
        send(8'd35);
        check("recover_valid", avg_valid, 1);
        check("recover_avg", avg_dist, 35);
        idle(1);
        check("recover_zone", zone, 1);

        // sample on the exact expiry cycle
        do_reset();
        send(8'd100);
        idle(999);
        send(8'd50);
        check("expiry_avg", avg_dist, 87);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("expiry_zone%0d", k), zone, 0);
            idle(1);
        end

        // reset mid-WARN with avg_valid pending
        do_reset();
        send(8'd30);
        idle(3);
        check("pre_rst_zone", zone, 1);
        distance   = 8'd30;
        dist_valid = 1'b1;
        idle(1);
        dist_valid = 1'b0;
        check("pre_rst_valid", avg_valid, 1);
        rst = 1'b1;
        idle(1);
        check("midrst_avg", avg_dist, 0);
        check("midrst_valid", avg_valid, 0);
        check("midrst_zone", zone, 3);
        check("midrst_buzz", buzzer, 0);
        rst = 1'b0;

        // full-scale sum without overflow
        send(8'd200);
        for (int i = 0; i < 4; i++) begin
            send(8'd255);
            check($sformatf("big_avg%0d", i), avg_dist, exp_big[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
